// File: rtl/led_pkg.sv
// Shared definitions for the LED colour path: fade command encodings and
// hue-wheel constants used by the sequencer and the fade stages.
package led_pkg;

  typedef enum logic [1:0] {
    PWM_INC   = 2'b00,
    PWM_DEC   = 2'b01,
    HIGH_HOLD = 2'b10,
    LOW_HOLD  = 2'b11
  } fade_state_t;

  localparam int NUM_PHASES = 6;

  // Running the wheel backwards retraces each ramp, so only the ramps swap.
  function automatic fade_state_t orient_ramp(input fade_state_t s, input logic dir);
    fade_state_t r;
    r = s;
    if (dir) begin
      if (s == PWM_INC)      r = PWM_DEC;
      else if (s == PWM_DEC) r = PWM_INC;
    end
    return r;
  endfunction

endpackage

// File: rtl/phase_decoder.sv
// Combinational decode of hue-wheel phase and direction into the three
// per-channel fade commands.
module phase_decoder
  import led_pkg::*;
(
  input  logic [2:0] phase,
  input  logic       dir,
  output logic [1:0] red_state,
  output logic [1:0] green_state,
  output logic [1:0] blue_state
);

  fade_state_t red_fwd;
  fade_state_t green_fwd;
  fade_state_t blue_fwd;

  // Forward hue wheel; unreachable codes park every channel dark.
  always_comb begin
    red_fwd   = LOW_HOLD;
    green_fwd = LOW_HOLD;
    blue_fwd  = LOW_HOLD;
    case (phase)
      3'd0: begin red_fwd = HIGH_HOLD; green_fwd = PWM_INC;   blue_fwd = LOW_HOLD;  end
      3'd1: begin red_fwd = PWM_DEC;   green_fwd = HIGH_HOLD; blue_fwd = LOW_HOLD;  end
      3'd2: begin red_fwd = LOW_HOLD;  green_fwd = HIGH_HOLD; blue_fwd = PWM_INC;   end
      3'd3: begin red_fwd = LOW_HOLD;  green_fwd = PWM_DEC;   blue_fwd = HIGH_HOLD; end
      3'd4: begin red_fwd = PWM_INC;   green_fwd = LOW_HOLD;  blue_fwd = HIGH_HOLD; end
      3'd5: begin red_fwd = HIGH_HOLD; green_fwd = LOW_HOLD;  blue_fwd = PWM_DEC;   end
      default: ;
    endcase
  end

  assign red_state   = orient_ramp(red_fwd, dir);
  assign green_state = orient_ramp(green_fwd, dir);
  assign blue_state  = orient_ramp(blue_fwd, dir);

endmodule

// File: rtl/color_phase_sequencer.sv
// Steps three fade channels around a six-phase hue wheel, one phase per full
// fade ramp, with pause and boundary-synchronised direction reversal.
module color_phase_sequencer
  import led_pkg::*;
#(
  parameter int INC_DEC_INTERVAL = 10000,
  parameter int INC_DEC_MAX      = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       reverse,
  output logic [1:0] red_state,
  output logic [1:0] green_state,
  output logic [1:0] blue_state,
  output logic [2:0] phase,
  output logic       phase_strobe
);

  localparam int TW = (INC_DEC_INTERVAL > 1) ? $clog2(INC_DEC_INTERVAL) : 1;
  localparam int SW = (INC_DEC_MAX > 1) ? $clog2(INC_DEC_MAX) : 1;
  localparam logic [TW-1:0] TCNT_LAST = TW'(INC_DEC_INTERVAL - 1);
  localparam logic [SW-1:0] SCNT_LAST = SW'(INC_DEC_MAX - 1);
  localparam logic [2:0]    PHASE_LAST = 3'(NUM_PHASES - 1);

  logic [TW-1:0] tcnt;
  logic [SW-1:0] scnt;
  logic [2:0]    phase_q;
  logic          dir;
  logic          tick_end;
  logic          boundary;
  logic [2:0]    phase_next;

  assign tick_end = (tcnt == TCNT_LAST);
  assign boundary = enable && tick_end && (scnt == SCNT_LAST);

  always_comb begin
    phase_next = phase_q;
    if (!dir) phase_next = (phase_q == PHASE_LAST) ? 3'd0 : phase_q + 3'd1;
    else      phase_next = (phase_q == 3'd0) ? PHASE_LAST : phase_q - 3'd1;
  end

  // A direction mismatch at a boundary spends that boundary turning around,
  // so the segment just finished is retraced rather than skipped.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt         <= '0;
      scnt         <= '0;
      phase_q      <= 3'd0;
      dir          <= 1'b0;
      phase_strobe <= 1'b0;
    end else begin
      phase_strobe <= boundary;
      if (enable) begin
        tcnt <= tick_end ? '0 : tcnt + 1'b1;
        if (tick_end) scnt <= (scnt == SCNT_LAST) ? '0 : scnt + 1'b1;
      end
      if (boundary) begin
        if (reverse == dir) phase_q <= phase_next;
        else                dir     <= reverse;
      end
    end
  end

  assign phase = phase_q;

  phase_decoder u_decoder (
    .phase       (phase_q),
    .dir         (dir),
    .red_state   (red_state),
    .green_state (green_state),
    .blue_state  (blue_state)
  );

endmodule

// File: tb/tb_color_phase_sequencer.sv
// Self-checking bench for color_phase_sequencer with a 12-cycle phase:
// a table of boundary outcomes plus hand-written pause/reset/toggle sequences.
module tb_color_phase_sequencer;

  localparam int INTERVAL  = 4;
  localparam int STEPS     = 3;
  localparam int PHASE_LEN = INTERVAL * STEPS;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       reverse;
  logic [1:0] red_state;
  logic [1:0] green_state;
  logic [1:0] blue_state;
  logic [2:0] phase;
  logic       phase_strobe;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] ph;
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } exp_t;

  typedef struct {
    logic rev;
    exp_t exp;
  } vec_t;

  exp_t sb[$];
  exp_t held;
  vec_t vecs[16];

  color_phase_sequencer #(
    .INC_DEC_INTERVAL (INTERVAL),
    .INC_DEC_MAX      (STEPS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .reverse      (reverse),
    .red_state    (red_state),
    .green_state  (green_state),
    .blue_state   (blue_state),
    .phase        (phase),
    .phase_strobe (phase_strobe)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk_exp(input logic [2:0] ph, input logic [1:0] r,
                                  input logic [1:0] g, input logic [1:0] b);
    exp_t e;
    e.ph = ph; e.r = r; e.g = g; e.b = b;
    return e;
  endfunction

  function automatic vec_t mk_vec(input logic rev, input logic [2:0] ph, input logic [1:0] r,
                                  input logic [1:0] g, input logic [1:0] b);
    vec_t v;
    v.rev = rev;
    v.exp = mk_exp(ph, r, g, b);
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic check_outputs(input string name, input exp_t e);
    check({name, "_phase"}, 16'(phase), 16'(e.ph));
    check({name, "_rgb"}, 16'({red_state, green_state, blue_state}), 16'({e.r, e.g, e.b}));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock with no boundary expected: strobe low and outputs unchanged.
  task automatic idle_step(input string name);
    step();
    check({name, "_nostrobe"}, 16'(phase_strobe), 16'd0);
    check({name, "_hold"}, 16'({phase, red_state, green_state, blue_state}),
          16'({held.ph, held.r, held.g, held.b}));
  endtask

  // Clock until a strobe (bounded), checking the gap and popping the scoreboard.
  task automatic run_to_strobe(input string name, input int gap, input int rev_at, input logic rev_val);
    int   n    = 0;
    bit   seen = 0;
    exp_t e;
    while (!seen && n < gap + 8) begin
      if (n == rev_at) reverse = rev_val;
      step();
      n++;
      if (phase_strobe) seen = 1;
      else check({name, "_hold"}, 16'({phase, red_state, green_state, blue_state}),
                 16'({held.ph, held.r, held.g, held.b}));
    end
    check({name, "_gap"}, 16'(n), 16'(gap));
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s_scoreboard: got empty queue, expected an entry", name);
    end else begin
      e = sb.pop_front();
      check_outputs(name, e);
      held = e;
    end
  endtask

  initial begin
    // Boundary outcomes from reset: forward lap, reversal mid phase 2, reverse wrap, turn back.
    vecs[0]  = mk_vec(1'b0, 3'd1, 2'b01, 2'b10, 2'b11);
    vecs[1]  = mk_vec(1'b0, 3'd2, 2'b11, 2'b10, 2'b00);
    vecs[2]  = mk_vec(1'b0, 3'd3, 2'b11, 2'b01, 2'b10);
    vecs[3]  = mk_vec(1'b0, 3'd4, 2'b00, 2'b11, 2'b10);
    vecs[4]  = mk_vec(1'b0, 3'd5, 2'b10, 2'b11, 2'b01);
    vecs[5]  = mk_vec(1'b0, 3'd0, 2'b10, 2'b00, 2'b11);
    vecs[6]  = mk_vec(1'b0, 3'd1, 2'b01, 2'b10, 2'b11);
    vecs[7]  = mk_vec(1'b0, 3'd2, 2'b11, 2'b10, 2'b00);
    vecs[8]  = mk_vec(1'b1, 3'd2, 2'b11, 2'b10, 2'b01);
    vecs[9]  = mk_vec(1'b1, 3'd1, 2'b00, 2'b10, 2'b11);
    vecs[10] = mk_vec(1'b1, 3'd0, 2'b10, 2'b01, 2'b11);
    vecs[11] = mk_vec(1'b1, 3'd5, 2'b10, 2'b11, 2'b00);
    vecs[12] = mk_vec(1'b1, 3'd4, 2'b01, 2'b11, 2'b10);
    vecs[13] = mk_vec(1'b1, 3'd3, 2'b11, 2'b00, 2'b10);
    vecs[14] = mk_vec(1'b0, 3'd3, 2'b11, 2'b01, 2'b10);
    vecs[15] = mk_vec(1'b0, 3'd4, 2'b00, 2'b11, 2'b10);

    rst     = 1'b1;
    enable  = 1'b1;
    reverse = 1'b0;
    repeat (3) step();
    held = mk_exp(3'd0, 2'b10, 2'b00, 2'b11);
    check_outputs("reset", held);
    check("reset_strobe", 16'(phase_strobe), 16'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      sb.push_back(vecs[i].exp);
      run_to_strobe($sformatf("vec%0d", i), PHASE_LEN, PHASE_LEN / 2, vecs[i].rev);
    end

    // Pause at tcnt=2 for 20 cycles; 10 enabled cycles remain afterwards.
    idle_step("pre_pause");
    idle_step("pre_pause");
    enable = 1'b0;
    repeat (20) idle_step("paused");
    enable = 1'b1;
    sb.push_back(mk_exp(3'd5, 2'b10, 2'b11, 2'b01));
    run_to_strobe("after_pause", 10, -1, 1'b0);

    // Enable dropped exactly on the boundary cycle: fires on the first enabled cycle.
    repeat (PHASE_LEN - 1) idle_step("approach");
    enable = 1'b0;
    repeat (3) idle_step("held_at_max");
    enable = 1'b1;
    sb.push_back(mk_exp(3'd0, 2'b10, 2'b00, 2'b11));
    run_to_strobe("late_boundary", 1, -1, 1'b0);

    // Reverse pulsed between boundaries while dir=0 must not flip direction.
    reverse = 1'b1;
    repeat (4) idle_step("toggle");
    reverse = 1'b0;
    sb.push_back(mk_exp(3'd1, 2'b01, 2'b10, 2'b11));
    run_to_strobe("toggle", PHASE_LEN - 4, -1, 1'b0);

    // Reach phase 2 with dir=1, then reset mid-phase.
    sb.push_back(mk_exp(3'd2, 2'b11, 2'b10, 2'b00));
    run_to_strobe("to_ph2", PHASE_LEN, -1, 1'b0);
    sb.push_back(mk_exp(3'd2, 2'b11, 2'b10, 2'b01));
    run_to_strobe("turn_ph2", PHASE_LEN, 0, 1'b1);
    repeat (5) idle_step("pre_reset");
    rst     = 1'b1;
    reverse = 1'b0;
    step();
    held = mk_exp(3'd0, 2'b10, 2'b00, 2'b11);
    check_outputs("mid_reset", held);
    check("mid_reset_strobe", 16'(phase_strobe), 16'd0);
    rst = 1'b0;
    sb.push_back(mk_exp(3'd1, 2'b01, 2'b10, 2'b11));
    run_to_strobe("post_reset", PHASE_LEN, -1, 1'b0);

    check("scoreboard_empty", 16'(sb.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/color_phase_sequencer.md
# color_phase_sequencer

Generates the per-channel fade commands (red, green, blue) that drive three `fade` instances, stepping through a six-phase hue wheel. It sits directly upstream of the fade stages. Each output is a 2-bit fade state. Phase length equals one full fade ramp, so every channel reaches its end value exactly at a phase boundary. Supports pause and run-time direction reversal.

## Interface
- `INC_DEC_INTERVAL`, default 10000: clk cycles per fade tick. Must match the downstream fade stages.
- `INC_DEC_MAX`, default 200: fade ticks per phase. One phase = `INC_DEC_INTERVAL*INC_DEC_MAX` cycles.
- `clk`, input, 1: clock.
- `rst`, input, 1: reset. Synchronous, active-high.
- `enable`, input, 1: high = advance timing; low = freeze counters and phase.
- `reverse`, input, 1: requested direction (0 = forward hue, 1 = reverse). Sampled only at phase boundaries.
- `red_state`, output, 2: fade command for the red channel.
- `green_state`, output, 2: fade command for the green channel.
- `blue_state`, output, 2: fade command for the blue channel.
- `phase`, output, 3: current phase index, 0..5.
- `phase_strobe`, output, 1: one-cycle pulse on each phase change.

## Operation
- Fade state encoding:
  - PWM_INC = 2'b00
  - PWM_DEC = 2'b01
  - HIGH_HOLD = 2'b10
  - LOW_HOLD = 2'b11
- Forward decode, listed as phase: R/G/B.
  - 0: HIGH / INC / LOW
  - 1: DEC / HIGH / LOW
  - 2: LOW / HIGH / INC
  - 3: LOW / DEC / HIGH
  - 4: INC / LOW / HIGH
  - 5: HIGH / LOW / DEC
- When `dir`=1, the decode for the same phase swaps INC and DEC. HIGH_HOLD and LOW_HOLD are unchanged.
- Output decode:
  - State outputs are a combinational decode of the registered `phase` and `dir`.
  - `phase` output equals the phase register.
- Tick counter `tcnt` counts 0..INC_DEC_INTERVAL-1 and wraps. Width is $clog2(INC_DEC_INTERVAL).
- Step counter `scnt` increments when `tcnt` wraps, counts 0..INC_DEC_MAX-1, and wraps. Width is $clog2(INC_DEC_MAX).
- A boundary event occurs when `enable`=1, `tcnt`=INC_DEC_INTERVAL-1, and `scnt`=INC_DEC_MAX-1. At a boundary:
  - If `reverse`==`dir`: phase advances by +1 (dir 0) or −1 (dir 1), mod 6. 5→0 forward; 0→5 reverse.
  - If `reverse`!=`dir`: `dir` ← `reverse` and the phase is unchanged. The same segment is retraced in the opposite direction.
  - `phase_strobe` pulses in both cases.
- `enable`=0: `tcnt`, `scnt`, `phase`, and `dir` hold, and `phase_strobe`=0.
  - Outputs keep their current values, so downstream fades saturate at their end value.
- `reverse` changes between boundaries have no effect until the next boundary.
- Phase register never leaves 0..5.

## Timing
- Reset values:
  - `phase`=0, `dir`=0, `tcnt`=0, `scnt`=0, `phase_strobe`=0.
  - `red_state`=2'b10, `green_state`=2'b00, `blue_state`=2'b11.
- Phase change is registered at the boundary edge. New `phase` and decoded states are visible from the next cycle, with 0 cycles of additional latency.
- `phase_strobe` is high for exactly the first cycle the new value (or new `dir`) is visible.
- With `enable` held high, successive strobes are exactly INC_DEC_INTERVAL*INC_DEC_MAX cycles apart.
- Tick alignment:
  - `tcnt` resets with the fade stages, so boundaries coincide with fade ticks.
  - The tick counter runs only while enabled. Downstream alignment after a pause is not guaranteed and does not need to be.
- `rst` mid-phase returns to the reset values on the next edge. `rst` takes priority over `enable` and the boundary.
- `enable` deasserted on the boundary cycle means no advance. The boundary fires on the first enabled cycle with both counters at max.

## Structure
- Shared package `led_pkg`:
  - `fade_state_t` enum holding the four encodings. `fade` migrates to it.
  - `NUM_PHASES`=6.
- Sub-module `phase_decoder`: purely combinational. Maps `phase` and `dir` to the three `fade_state_t` outputs.
- Top level holds both counters, the `phase`/`dir` registers, and strobe generation.

## Test plan
Bench parameters: INC_DEC_INTERVAL=4, INC_DEC_MAX=3, giving a 12-cycle phase.

1. Release reset with enable=1 and reverse=0.
   - Outputs are R=10, G=00, B=11 at phase 0.
   - Strobes occur at cycles 12, 24, …; phase goes 1,2,3,4,5,0.
   - At phase 3 the outputs are 11/01/10.
2. Set reverse=1 mid-phase 2.
   - Phase stays 2 at the next boundary with dir=1, strobe=1, and outputs 11/10/01.
   - Following boundaries give phase 1, then 0, then 5.
3. Reverse wrap: with dir=1 and phase=0, the boundary yields phase=5 and outputs 10/11/00.
4. Deassert enable for 20 cycles at tcnt=2.
   - No strobe and outputs unchanged.
   - After re-enable, the next strobe arrives after the remaining 10 enabled cycles.
5. Assert rst at cycle 30 while in phase 2.
   - The next cycle shows phase=0, R/G/B=10/00/11, and strobe=0.
   - The first strobe comes 12 cycles after rst is released.
6. Toggle reverse 1→0 between boundaries while dir=0: the next boundary advances normally (+1), with no spurious direction flip.
